button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 161 ++++++++++++++++
 tb/tb_button_conditioner.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Debounced, prioritised move strobes for four active-low buttons.
// Define AUTO_REPEAT_EN to re-issue held buttons after REPEAT_DELAY/REPEAT_PERIOD.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic up,
  input  logic down,
  input  logic left,
  input  logic right,
  output logic up_o,
  output logic down_o,
  output logic left_o,
  output logic right_o,
  output logic pending
);

  if (!(DEBOUNCE_CYCLES >= 2 && DEBOUNCE_CYCLES < 2**24 &&
        REPEAT_DELAY > 0 && REPEAT_PERIOD > 0)) begin : g_bad_cfg
    $error("button_conditioner: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CNT,
    HELD,
    REL_CNT
  } state_t;

  localparam logic [23:0] DB = 24'(DEBOUNCE_CYCLES);

  logic [3:0]  s1, s2;
  logic [3:0]  pend, grant, set, rset;
  state_t      st   [4];
  state_t      st_n [4];
  logic [23:0] cnt   [4];
  logic [23:0] cnt_n [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      st_n[i]  = st[i];
      cnt_n[i] = cnt[i];
      set[i]   = 1'b0;
      unique case (st[i])
        IDLE: if (!s2[i]) begin
          st_n[i]  = PRESS_CNT;
          cnt_n[i] = 24'd1;
        end
        PRESS_CNT: begin
          if (s2[i]) begin
            st_n[i]  = IDLE;
            cnt_n[i] = '0;
          end else if (cnt[i] == DB) begin
            st_n[i]  = HELD;
            cnt_n[i] = '0;
            set[i]   = 1'b1;
          end else begin
            cnt_n[i] = cnt[i] + 24'd1;
          end
        end
        HELD: if (s2[i]) begin
          st_n[i]  = REL_CNT;
          cnt_n[i] = 24'd1;
        end
        REL_CNT: begin
          if (!s2[i]) begin
            st_n[i]  = HELD;
            cnt_n[i] = '0;
          end else if (cnt[i] == DB) begin
            st_n[i]  = IDLE;
            cnt_n[i] = '0;
          end else begin
            cnt_n[i] = cnt[i] + 24'd1;
          end
        end
        default: begin
          st_n[i]  = IDLE;
          cnt_n[i] = '0;
        end
      endcase
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [31:0] RD = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RP = 32'(REPEAT_PERIOD - 1);

  logic [31:0] rpt [4];
  logic [3:0]  rfirst;

  always_comb begin
    rset = '0;
    for (int i = 0; i < 4; i++)
      rset[i] = (st[i] == HELD) && (st_n[i] == HELD) &&
                (rpt[i] == (rfirst[i] ? RD : RP));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset || st[i] != HELD) begin
        rpt[i]    <= '0;
        rfirst[i] <= 1'b1;
      end else if (rset[i]) begin
        rpt[i]    <= '0;
        rfirst[i] <= 1'b0;
      end else begin
        rpt[i]    <= rpt[i] + 32'd1;
      end
    end
  end
`else
  assign rset = '0;
`endif

  // Lowest index wins: up > down > left > right.
  always_comb begin
    grant = '0;
    priority case (1'b1)
      pend[0]: grant = 4'b0001;
      pend[1]: grant = 4'b0010;
      pend[2]: grant = 4'b0100;
      pend[3]: grant = 4'b1000;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= '1;
      s2      <= '1;
      pend    <= '0;
      up_o    <= 1'b1;
      down_o  <= 1'b1;
      left_o  <= 1'b1;
      right_o <= 1'b1;
      pending <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
    end else begin
      s1      <= {right, left, down, up};
      s2      <= s1;
      // A new set beats the clear from issuing in the same cycle.
      pend    <= (pend & ~grant) | set | rset;
      up_o    <= ~grant[0];
      down_o  <= ~grant[1];
      left_o  <= ~grant[2];
      right_o <= ~grant[3];
      pending <= |pend;
      for (int i = 0; i < 4; i++) begin
        st[i]  <= st_n[i];
        cnt[i] <= cnt_n[i];
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4.
// Vector table plus hand sequences for bounce, glitch, reset and repeat.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset, up, down, left, right;
  logic up_o, down_o, left_o, right_o, pending;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .up     (up),
    .down   (down),
    .left   (left),
    .right  (right),
    .up_o   (up_o),
    .down_o (down_o),
    .left_o (left_o),
    .right_o(right_o),
    .pending(pending)
  );

  typedef struct {
    logic       r, u, d, l, rt;
    logic [4:0] exp;
  } vec_t;

  localparam logic [4:0] IDL = 5'b11110;

  vec_t vq[$];
  int nvec = 0;
  int nerr = 0;
  int tick, nu, nd, nl, nr, np, fu, fl, ld, nmulti;

  task automatic add(input logic r, u, d, l, rt, input logic [4:0] e);
    vec_t v;
    v.r = r; v.u = u; v.d = d; v.l = l; v.rt = rt; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr();
    tick = 0; nu = 0; nd = 0; nl = 0; nr = 0; np = 0;
    fu = 0; fl = 0; ld = 0;
  endtask

  task automatic cyc(input logic r, u, d, l, rt);
    @(negedge clk);
    reset = r; up = u; down = d; left = l; right = rt;
    @(posedge clk);
    #1;
    tick++;
    if (!up_o) begin nu++; if (fu == 0) fu = tick; end
    if (!down_o) begin nd++; ld = tick; end
    if (!left_o) begin nl++; if (fl == 0) fl = tick; end
    if (!right_o) nr++;
    if (pending) np++;
    if ((4 - (up_o + down_o + left_o + right_o)) > 1) nmulti++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 1, 1, 1);
  endtask

  initial begin
    logic [4:0] e;
    reset = 1'b1; up = 1'b1; down = 1'b1; left = 1'b1; right = 1'b1;
    nmulti = 0;
    clr();

    for (int k = 0; k < 2; k++) add(1, 1, 1, 1, 1, IDL);
    for (int k = 0; k < 12; k++)
      add(0, 0, 1, 1, 1, (k == 7) ? 5'b01111 : IDL);
    for (int k = 0; k < 8; k++) add(0, 1, 1, 1, 1, IDL);
    for (int k = 0; k < 14; k++) begin
      case (k)
        7:       e = 5'b01111;
        8:       e = 5'b10111;
        9:       e = 5'b11011;
        10:      e = 5'b11101;
        default: e = IDL;
      endcase
      add(0, 0, 0, 0, 0, e);
    end
    for (int k = 0; k < 8; k++) add(0, 1, 1, 1, 1, IDL);

    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].r; up = vq[i].u; down = vq[i].d;
      left = vq[i].l; right = vq[i].rt;
      @(posedge clk);
      #1;
      nvec++;
      if ({up_o, down_o, left_o, right_o, pending} !== vq[i].exp) begin
        nerr++;
        $display("FAIL vec%0d: got %b expected %b", i,
                 {up_o, down_o, left_o, right_o, pending}, vq[i].exp);
      end
    end

    clr();
    cyc(0, 1, 1, 0, 1); cyc(0, 1, 1, 1, 1); cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 1, 1, 1); cyc(0, 1, 1, 0, 1);
    idle(15);
    chk("bounce_left_strobes", nl, 0);
    chk("bounce_pending", np, 0);
    clr();
    for (int k = 0; k < 10; k++) cyc(0, 1, 1, 0, 1);
    chk("left_after_bounce_latency", fl, 8);
    chk("left_after_bounce_count", nl, 1);
    idle(10);

    clr();
    for (int k = 0; k < 12; k++) cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 1);
    for (int k = 0; k < 12; k++) cyc(0, 1, 1, 1, 0);
    idle(10);
    chk("glitch_right_strobes", nr, 1);

    clr();
    for (int k = 0; k < 4; k++) cyc(0, 1, 0, 1, 1);
    cyc(1, 1, 0, 1, 1);
    chk("reset_outputs", {up_o, down_o, left_o, right_o, pending}, IDL);
    chk("reset_no_early_down", nd, 0);
    tick = 0;
    for (int k = 0; k < 14; k++) cyc(0, 1, 0, 1, 1);
    chk("reset_down_latency", ld, 8);
    chk("reset_down_count", nd, 1);
    idle(10);

    clr();
    for (int k = 0; k < 7; k++) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("reset_pend_outputs", {up_o, down_o, left_o, right_o, pending}, IDL);
    for (int k = 0; k < 14; k++) cyc(0, 0, 0, 0, 0);
    idle(10);
    chk("reset_pend_up", nu, 1);
    chk("reset_pend_down", nd, 1);
    chk("reset_pend_left", nl, 1);
    chk("reset_pend_right", nr, 1);

    clr();
    for (int k = 0; k < 60; k++) cyc(0, 0, 1, 1, 1);
    idle(10);
    chk("repeat_first_latency", fu, 8);
`ifdef AUTO_REPEAT_EN
    chk("repeat_up_strobes", nu, 6);
`else
    chk("repeat_up_strobes", nu, 1);
`endif

    chk("one_strobe_per_cycle", nmulti, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
